// File: rtl/unified_mem_minscan.sv
// Unified instruction/data word memory with a background
// scanner that tracks the signed minimum of a fixed array window.
module unified_mem_minscan #(
  parameter int MEM_WORDS = 4096,
  parameter int ARR_BASE  = 1000,
  parameter int ARR_LEN   = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_data_adr,
  input  logic [31:0] mem_data_in,
  input  logic        mrd,
  input  logic        mwr,
  output logic [31:0] mem_out,
  output logic [31:0] min_value,
  output logic [4:0]  min_index,
  output logic        min_valid
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [31:0] ARR_LO = 32'(ARR_BASE / 4);
  localparam logic [31:0] ARR_HI = 32'(ARR_BASE / 4 + ARR_LEN - 1);
  localparam logic [4:0]  LAST   = 5'(ARR_LEN - 1);

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  logic [31:0]   mem [MEM_WORDS];
  logic [AW-1:0] wa;
  logic [AW-1:0] scan_adr;
  logic [31:0]   scan_word;
  logic          win_wr;
  logic          take;
  logic          unused_adr;

  state_t      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [31:0] run_min_q, run_min_d;
  logic [4:0]  run_idx_q, run_idx_d;
  logic [31:0] min_value_d;
  logic [4:0]  min_index_d;
  logic        min_valid_d;
  logic [31:0] cand_min;
  logic [4:0]  cand_idx;

  assign wa         = inst_data_adr[AW+1:2];
  assign unused_adr = ^{inst_data_adr[31:AW+2], inst_data_adr[1:0]};
  assign mem_out    = mrd ? mem[wa] : 32'h0;

  assign win_wr = mwr
               && (32'(wa) >= ARR_LO)
               && (32'(wa) <= ARR_HI);

  assign scan_adr  = AW'(ARR_BASE / 4) + AW'(idx_q);
  assign scan_word = mem[scan_adr];

  // word 0 always seeds the running min; later words need a strict win
  assign take = (idx_q == 5'd0)
             || ($signed(scan_word) < $signed(run_min_q));
  assign cand_min = take ? scan_word : run_min_q;
  assign cand_idx = take ? idx_q : run_idx_q;

  // memory array write port; contents survive reset
  always_ff @(posedge clk) begin
    if (mwr) mem[wa] <= mem_data_in;
  end

  // scanner next-state: an array write restarts from any state
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    run_min_d   = run_min_q;
    run_idx_d   = run_idx_q;
    min_value_d = min_value;
    min_index_d = min_index;
    min_valid_d = min_valid;
    if (win_wr) begin
      state_d     = SCAN;
      idx_d       = 5'd0;
      min_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;
        SCAN: begin
          run_min_d = cand_min;
          run_idx_d = cand_idx;
          if (idx_q == LAST) begin
            min_value_d = cand_min;
            min_index_d = cand_idx;
            min_valid_d = 1'b1;
            state_d     = IDLE;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  // scanner registers; reset parks the engine at the start of a scan
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= SCAN;
      idx_q     <= 5'd0;
      run_min_q <= 32'h0;
      run_idx_q <= 5'd0;
      min_value <= 32'h0;
      min_index <= 5'd0;
      min_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      run_min_q <= run_min_d;
      run_idx_q <= run_idx_d;
      min_value <= min_value_d;
      min_index <= min_index_d;
      min_valid <= min_valid_d;
    end
  end

endmodule

// File: tb/tb_unified_mem_minscan.sv
// Random and directed check of unified_mem_minscan
// against an array-level reference model.
module tb_unified_mem_minscan;

  localparam int MW  = 4096;
  localparam int AB  = 1000;
  localparam int AL  = 20;
  localparam int AW0 = AB / 4;

  logic        clk;
  logic        rst;
  logic [31:0] adr;
  logic [31:0] din;
  logic        mrd;
  logic        mwr;
  logic [31:0] mem_out;
  logic [31:0] min_value;
  logic [4:0]  min_index;
  logic        min_valid;

  unified_mem_minscan #(
    .MEM_WORDS(MW),
    .ARR_BASE (AB),
    .ARR_LEN  (AL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_data_adr(adr),
    .mem_data_in  (din),
    .mrd          (mrd),
    .mwr          (mwr),
    .mem_out      (mem_out),
    .min_value    (min_value),
    .min_index    (min_index),
    .min_valid    (min_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] shadow [MW];
  logic [31:0] e_val;
  logic [4:0]  e_idx;
  logic        e_valid;
  bit          scanning;
  int          cnt;
  int          n_chk;
  int          n_fail;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic ref_min(output logic [31:0] v, output logic [4:0] ix);
    v  = shadow[AW0];
    ix = 5'd0;
    for (int i = 1; i < AL; i++) begin
      if ($signed(shadow[AW0+i]) < $signed(v)) begin
        v  = shadow[AW0+i];
        ix = 5'(i);
      end
    end
  endtask

  task automatic step(input logic r, input logic [31:0] a,
                      input logic [31:0] d, input logic rd,
                      input logic wr);
    int w;
    w   = int'(a[13:2]);
    rst = r;
    adr = a;
    din = d;
    mrd = rd;
    mwr = wr;
    #1;
    chk("mem_out", mem_out, rd ? shadow[w] : 32'h0);
    @(posedge clk);
    if (wr) shadow[w] = d;
    if (!r) begin
      e_val    = 32'h0;
      e_idx    = 5'd0;
      e_valid  = 1'b0;
      scanning = 1'b1;
      cnt      = 0;
    end else if (wr && w >= AW0 && w < AW0 + AL) begin
      e_valid  = 1'b0;
      scanning = 1'b1;
      cnt      = 0;
    end else if (scanning) begin
      cnt++;
      if (cnt == AL) begin
        ref_min(e_val, e_idx);
        e_valid  = 1'b1;
        scanning = 1'b0;
      end
    end
    @(negedge clk);
    chk("min_valid", 32'(min_valid), 32'(e_valid));
    chk("min_value", min_value, e_val);
    chk("min_index", 32'(min_index), 32'(e_idx));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic wr_arr(input int i, input logic [31:0] v);
    step(1'b1, 32'(AB + 4 * i), v, 1'b0, 1'b1);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] old;
    n_chk    = 0;
    n_fail   = 0;
    scanning = 1'b1;
    cnt      = 0;
    e_val    = 32'h0;
    e_idx    = 5'd0;
    e_valid  = 1'b0;
    rst = 1'b0; adr = '0; din = '0; mrd = 1'b0; mwr = 1'b0;
    for (int i = 0; i < MW; i++) shadow[i] = 32'h0;

    for (int i = 0; i < MW; i++)
      step(1'b0, 32'(4 * i), $urandom, 1'b0, 1'b1);
    for (int i = 0; i < AL; i++)
      step(1'b0, 32'(AB + 4 * i), 32'(100 - i), 1'b0, 1'b1);
    chk("rst_valid", 32'(min_valid), 32'h0);
    chk("rst_value", min_value, 32'h0);
    chk("rst_index", 32'(min_index), 32'h0);

    idle(AL - 1);
    chk("desc_early", 32'(min_valid), 32'h0);
    idle(1);
    chk("desc_valid", 32'(min_valid), 32'h1);
    chk("desc_value", min_value, 32'd81);
    chk("desc_index", 32'(min_index), 32'd19);

    step(1'b1, 32'd1020, 32'hFFFF_FFFB, 1'b0, 1'b1);
    chk("neg_drop", 32'(min_valid), 32'h0);
    chk("neg_hold", min_value, 32'd81);
    idle(AL - 1);
    chk("neg_early", 32'(min_valid), 32'h0);
    idle(1);
    chk("neg_value", min_value, 32'hFFFF_FFFB);
    chk("neg_index", 32'(min_index), 32'd5);

    old = shadow[125];
    step(1'b1, 32'd500, 32'hDEAD_BEEF, 1'b1, 1'b1);
    chk("rw_new", mem_out, 32'hDEAD_BEEF);
    chk("rw_old_kept", 32'(old == 32'hDEAD_BEEF), 32'h0);
    step(1'b1, 32'd500, 32'h0, 1'b1, 1'b0);
    chk("rw_valid", 32'(min_valid), 32'h1);
    chk("rw_value", min_value, 32'hFFFF_FFFB);

    for (int i = 0; i < AL; i++)
      wr_arr(i, (i == 3 || i == 12) ? 32'd7 : 32'd50);
    idle(AL);
    chk("tie_value", min_value, 32'd7);
    chk("tie_index", 32'(min_index), 32'd3);

    wr_arr(0, 32'd50);
    idle(10);
    wr_arr(0, 32'hFFFF_FFFF);
    idle(AL - 1);
    chk("rs_early", 32'(min_valid), 32'h0);
    idle(1);
    chk("rs_valid", 32'(min_valid), 32'h1);
    chk("rs_value", min_value, 32'hFFFF_FFFF);
    chk("rs_index", 32'(min_index), 32'd0);

    step(1'b1, 32'h8000_0000 | 32'(AB + 4 * MW + 9), 32'hFFFF_FFF9,
         1'b0, 1'b1);
    idle(AL);
    chk("wrap_value", min_value, 32'hFFFF_FFF9);
    chk("wrap_index", 32'(min_index), 32'd2);

    wr_arr(1, 32'd0);
    idle(5);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("mrst_valid", 32'(min_valid), 32'h0);
    chk("mrst_value", min_value, 32'h0);
    chk("mrst_index", 32'(min_index), 32'h0);
    idle(AL - 1);
    chk("mrst_early", 32'(min_valid), 32'h0);
    idle(1);
    chk("mrst_done", 32'(min_valid), 32'h1);
    chk("mrst_min", min_value, 32'hFFFF_FFF9);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 1) == 0)
        a = 32'(AB + 4 * $urandom_range(0, AL - 1)
              + $urandom_range(0, 3))
          + ($urandom_range(0, 3) << 14);
      else
        a = $urandom;
      step($urandom_range(0, 299) != 0, a,
           ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 200)) - 32'd100
                                      : $urandom,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 15) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/unified_mem_minscan.md
UNIFIED_MEM_MINSCAN -- requirements
Module: unified_mem_minscan

Interface
REQ-001 Parameter MEM_WORDS, default 4096, SHALL set the memory depth in 32-bit words.
REQ-002 Parameter ARR_BASE, default 1000, SHALL set the word-aligned byte address of the monitored array.
REQ-003 Parameter ARR_LEN, default 20, range 1..32, SHALL set the monitored array length in words.
REQ-004 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 rst  input  1  SHALL be the reset; synchronous, active-low.
REQ-006 inst_data_adr  input  32  SHALL be the byte address for instruction or data access.
REQ-007 mem_data_in  input  32  SHALL be the write data.
REQ-008 mrd  input  1  SHALL be the read enable.
REQ-009 mwr  input  1  SHALL be the write enable.
REQ-010 mem_out  output  32  SHALL be the read data returned to the processor.
REQ-011 min_value  output  32  SHALL be the signed minimum of the monitored array.
REQ-012 min_index  output  5  SHALL be the array index (0-based) of min_value.
REQ-013 min_valid  output  1  SHALL be high when min_value/min_index reflect current array contents.

Function
REQ-014 Word select SHALL be inst_data_adr[log2(MEM_WORDS)+1:2]; bits [1:0] and upper bits ignored; out-of-range addresses wrap modulo MEM_WORDS.
REQ-015 Read SHALL be combinational: mem_out = word at address when mrd=1, else 32'h0.
REQ-016 Write SHALL commit mem_data_in on the rising edge when mwr=1.
REQ-017 mrd=1 and mwr=1 together SHALL show the pre-write word on mem_out during that cycle; the write still commits.
REQ-018 Memory contents SHALL be unaffected by rst; contents are preloaded at simulation start.
REQ-019 A scan engine SHALL use a dedicated internal read port, independent of mrd/mem_out.
REQ-020 FSM states SHALL be IDLE and SCAN; registers idx (5 bits), run_min (32), run_idx (5).
REQ-021 In SCAN, each cycle SHALL read array word idx (address ARR_BASE/4+idx), post any write already committed.
REQ-022 idx=0 SHALL load run_min/run_idx unconditionally; idx>0 SHALL replace them only if word < run_min (signed, strict), so ties keep the lowest index.
REQ-023 On the edge processing idx=ARR_LEN-1, the engine SHALL copy the result (including that word) to min_value/min_index, set min_valid=1, enter IDLE.
REQ-024 Scan latency SHALL be exactly ARR_LEN cycles from SCAN entry to min_valid rising.
REQ-025 A write with word address in [ARR_BASE/4, ARR_BASE/4+ARR_LEN-1] SHALL, on its commit edge, set state=SCAN, idx=0, min_valid=0, from either IDLE or SCAN (restart).
REQ-026 Writes outside the array window SHALL not affect the FSM or min outputs.
REQ-027 min_value/min_index SHALL hold their last values while min_valid=0, until the next scan completes.
REQ-028 A qualifying write on the same edge as scan completion SHALL take priority: min_valid stays 0, scan restarts at idx=0.

Reset
REQ-029 rst=0 at a rising edge SHALL set min_value=0, min_index=0, min_valid=0, idx=0, state=SCAN, including mid-scan.
REQ-030 With rst=0, writes SHALL still commit and combinational reads still function; the FSM SHALL stay held at SCAN/idx=0.
REQ-031 The first edge with rst=1 SHALL process idx=0, so min_valid rises ARR_LEN cycles after reset release.

Verification
REQ-032 Preload array = 100,99,...,81; release reset -> after 20 cycles min_valid=1, min_value=81, min_index=19.
REQ-033 After REQ-032 settles, write -5 to byte 1020 (index 5) -> min_valid=0 next cycle, 20 cycles later min_value=-5, min_index=5.
REQ-034 Preload array with 7 at indices 3 and 12, all else 50 -> min_index=3 (tie keeps lowest).
REQ-035 During a scan at idx=10, write -1 to byte 1000 -> scan restarts; result -1/index 0 exactly 20 cycles after that write edge; no intermediate min_valid pulse.
REQ-036 Write 0xDEADBEEF to byte 500 with mrd=1 on same cycle -> mem_out shows old word that cycle, 0xDEADBEEF next cycle; min outputs and min_valid unchanged.
REQ-037 Assert rst=0 for one edge mid-scan -> all min outputs 0, min_valid=0; scan completes ARR_LEN cycles after release.
